// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Multi-cycle instruction sequencer. Steps each instruction
//                through FETCH/DECODE/EXEC/MEM/WB, waits on the data-memory
//                ready handshake with a timeout fault, and keeps a saturating
//                retired-instruction counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter int OP_W        = 3,
  parameter int FA_W        = 3,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  opcode,
  input  logic [FA_W-1:0]  funcA,
  input  logic             funcB,
  input  logic             overflow,
  input  logic             memReady,
  output logic             irWrite,
  output logic             pcWrite,
  output logic             branch,
  output logic             taken,
  output logic             regWrite,
  output logic             regDest,
  output logic             memRead,
  output logic             memWrite,
  output logic             memToReg,
  output logic             halt,
  output logic             fault,
  output logic             busy,
  output logic [CNT_W-1:0] instCount
);

  // Opcodes that steer the sequence; MATCH, LT and the remaining funcA codes
  // all fall through to the no-writeback path and need no constant.
  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_DIST  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_FUNCA = OP_W'(6);
  localparam logic [OP_W-1:0] OP_FUNCB = OP_W'(7);

  localparam logic [FA_W-1:0] FA_LSL   = FA_W'(0);
  localparam logic [FA_W-1:0] FA_LSR   = FA_W'(1);
  localparam logic [FA_W-1:0] FA_INCR  = FA_W'(2);
  localparam logic [FA_W-1:0] FA_ZERO  = FA_W'(5);
  localparam logic [FA_W-1:0] FA_HALT  = FA_W'(7);

  // Wait counter spans 0..MEM_TIMEOUT; reaching MEM_TIMEOUT without ready
  // means MEM_TIMEOUT+1 cycles have been spent, which is the fault point.
  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [WAIT_W-1:0] wait_q;
  logic              fault_q;
  logic              wait_clr;
  logic              wait_inc;
  logic              timeout;

  logic is_load;
  logic is_store;
  logic is_funca;
  logic is_funcb;
  logic is_halt;
  logic is_alu_wb;

  // Instruction class decode from the IR fields.
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_funca  = (opcode == OP_FUNCA);
  assign is_funcb  = (opcode == OP_FUNCB);
  assign is_halt   = is_funca && (funcA == FA_HALT);
  assign is_alu_wb = (opcode == OP_ADD) || (opcode == OP_DIST) ||
                     (is_funca && ((funcA == FA_LSL)  || (funcA == FA_LSR) ||
                                   (funcA == FA_INCR) || (funcA == FA_ZERO)));

  assign halt  = (state_q == S_HALTED);
  assign busy  = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign fault = fault_q;

  // State register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and decoded enables for the current step.
  always_comb begin
    state_d  = state_q;
    irWrite  = 1'b0;
    pcWrite  = 1'b0;
    branch   = 1'b0;
    taken    = 1'b0;
    regWrite = 1'b0;
    regDest  = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    memToReg = 1'b0;
    wait_clr = 1'b0;
    wait_inc = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        irWrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_funcb) begin
          branch  = 1'b1;
          taken   = (funcB == overflow);
          pcWrite = 1'b1;
          state_d = S_FETCH;
        end else if (is_halt) begin
          state_d = S_HALTED;
        end else if (is_load || is_store) begin
          wait_clr = 1'b1;
          state_d  = S_MEM;
        end else if (is_alu_wb) begin
          state_d = S_WB;
        end else begin
          // Compare-style and undefined operations retire without writeback.
          pcWrite = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        memRead  = is_load;
        memWrite = is_store;
        if (memReady) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            pcWrite = 1'b1;
            state_d = S_FETCH;
          end
        end else if (wait_q == WAIT_MAX) begin
          timeout = 1'b1;
          state_d = S_HALTED;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WB: begin
        regWrite = 1'b1;
        pcWrite  = 1'b1;
        regDest  = is_funca;
        memToReg = is_load;
        state_d  = S_FETCH;
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Memory wait counter and sticky timeout fault.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      if (wait_clr) begin
        wait_q <= '0;
      end else if (wait_inc) begin
        wait_q <= wait_q + 1'b1;
      end
      if (timeout) begin
        fault_q <= 1'b1;
      end
    end
  end

  // Retired-instruction counter, saturating at all-ones.
  always_ff @(posedge CLK) begin
    if (reset) begin
      instCount <= '0;
    end else if (pcWrite && (instCount != '1)) begin
      instCount <= instCount + 1'b1;
    end
  end

endmodule
`default_nettype wire
